// File: rtl/usb3_pkg.sv
// Shared constants and the per-byte LFSR step for the USB 3.0 receive descrambler.
package usb3_pkg;

  localparam logic [7:0]  K_COM     = 8'hBC;
  localparam logic [7:0]  K_SKP     = 8'h3C;
  // Feedback taps for x^16+x^5+x^4+x^3+1 (the x^16 term is the shifted-out bit).
  localparam logic [15:0] LFSR_TAPS = 16'h0039;

  typedef struct packed {
    logic [15:0] next;
    logic [7:0]  key;
  } lfsr_step_t;

  // One byte step: key is the top LFSR byte bit-reversed, next state is eight Galois shifts.
  function automatic lfsr_step_t lfsr_step(input logic [15:0] state);
    lfsr_step_t r;
    logic [15:0] s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r.key[i] = state[15-i];
    end
    s = state;
    for (int i = 0; i < 8; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? LFSR_TAPS : 16'h0000);
    end
    r.next = s;
    return r;
  endfunction

endpackage

// File: rtl/usb3_rx_lfsr4.sv
// Four-lane keystream generator: chains the LFSR through lanes 0..3, reseeding on COM
// and holding on SKP.
module usb3_rx_lfsr4
  import usb3_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic [15:0] lfsr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  datak_i,
  output logic [31:0] key_o,
  output logic [15:0] lfsr_o
);

  logic [15:0] state;
  lfsr_step_t  step;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state = lfsr_i;
    step  = '0;
    key_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (datak_i[i] && data_i[8*i +: 8] == K_COM) begin
        state = LFSR_SEED;
      end else if (!(datak_i[i] && data_i[8*i +: 8] == K_SKP)) begin
        step           = lfsr_step(state);
        key_o[8*i +: 8] = step.key;
        state          = step.next;
      end
    end
    lfsr_o = state;
  end

endmodule

// File: rtl/usb3_descramble.sv
// USB 3.0 RX descrambler with optional SKP stripping and byte repacking.
// Define USB3_DESCRAMBLE_SKP_STRIP_EN to build the SKP stripper and pack buffer.
module usb3_descramble
  import usb3_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic        local_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] raw_data,
  input  logic [3:0]  raw_datak,
  input  logic        raw_active,
  output logic [31:0] proc_data,
  output logic [3:0]  proc_datak,
  output logic        proc_valid,
  output logic [15:0] skp_count,
  output logic        err_overflow
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] lane_key;
  logic [31:0] s1_data_q, s1_data_d;
  logic [3:0]  s1_datak_q;
  logic        s1_valid_q;
  logic [31:0] proc_data_q;
  logic [3:0]  proc_datak_q;
  logic        proc_valid_q;

  usb3_rx_lfsr4 #(.LFSR_SEED(LFSR_SEED)) u_lfsr4 (
    .lfsr_i  (lfsr_q),
    .data_i  (raw_data),
    .datak_i (raw_datak),
    .key_o   (lane_key),
    .lfsr_o  (lfsr_d)
  );

  // Only D bytes are keyed; K bytes (COM, SKP, others) always pass untouched.
  always_comb begin
    s1_data_d = raw_data;
    for (int i = 0; i < 4; i++) begin
      if (enable && !raw_datak[i]) begin
        s1_data_d[8*i +: 8] = raw_data[8*i +: 8] ^ lane_key[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      lfsr_q     <= LFSR_SEED;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_datak_q <= '0;
    end else begin
      s1_valid_q <= raw_active;
      if (raw_active) begin
        lfsr_q     <= lfsr_d;
        s1_data_q  <= s1_data_d;
        s1_datak_q <= raw_datak;
      end
    end
  end

`ifdef USB3_DESCRAMBLE_SKP_STRIP_EN
  logic [3:0]  lane_skp;
  logic [3:0]  s1_keep_q;
  logic [23:0] buf_q, buf_d;
  logic [2:0]  bufk_q, bufk_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] cat_data;
  logic [7:0]  cat_k;
  logic [3:0]  pos;
  logic [2:0]  n_skp;
  logic        emit;
  logic [15:0] skp_count_q;
  logic        err_q;

  always_comb begin
    lane_skp = '0;
    for (int i = 0; i < 4; i++) begin
      lane_skp[i] = raw_datak[i] && (raw_data[8*i +: 8] == K_SKP);
    end
  end

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      s1_keep_q <= '0;
    end else if (raw_active) begin
      s1_keep_q <= ~lane_skp;
    end
  end

  // Append kept lanes behind the residue; the buffer never holds more than 3 bytes
  // between cycles because 4 are drained whenever the fill reaches 4.
  always_comb begin
    cat_data = {40'h0, buf_q};
    cat_k    = {5'b0, bufk_q};
    pos      = {1'b0, cnt_q};
    n_skp    = '0;
    if (s1_valid_q) begin
      for (int i = 0; i < 4; i++) begin
        if (s1_keep_q[i]) begin
          cat_data[{pos[2:0], 3'b000} +: 8] = s1_data_q[8*i +: 8];
          cat_k[pos[2:0]]                   = s1_datak_q[i];
          pos                               = pos + 4'd1;
        end else begin
          n_skp = n_skp + 3'd1;
        end
      end
    end
    emit   = (pos >= 4'd4);
    buf_d  = emit ? cat_data[55:32] : cat_data[23:0];
    bufk_d = emit ? cat_k[6:4]      : cat_k[2:0];
    cnt_d  = emit ? 3'(pos - 4'd4)  : pos[2:0];
  end

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      buf_q        <= '0;
      bufk_q       <= '0;
      cnt_q        <= '0;
      proc_valid_q <= 1'b0;
      proc_data_q  <= '0;
      proc_datak_q <= '0;
      skp_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      bufk_q       <= bufk_d;
      cnt_q        <= cnt_d;
      proc_valid_q <= emit;
      if (emit) begin
        proc_data_q  <= cat_data[31:0];
        proc_datak_q <= cat_k[3:0];
      end
      skp_count_q  <= skp_count_q + {13'b0, n_skp};
      err_q        <= err_q | (pos > 4'd7);
    end
  end

  assign skp_count    = skp_count_q;
  assign err_overflow = err_q;
`else
  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      proc_valid_q <= 1'b0;
      proc_data_q  <= '0;
      proc_datak_q <= '0;
    end else begin
      proc_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        proc_data_q  <= s1_data_q;
        proc_datak_q <= s1_datak_q;
      end
    end
  end

  assign skp_count    = '0;
  assign err_overflow = 1'b0;
`endif

  assign proc_data  = proc_data_q;
  assign proc_datak = proc_datak_q;
  assign proc_valid = proc_valid_q;

endmodule

// File: tb/tb_usb3_descramble.sv
// Directed bench for usb3_descramble; a bit-serial scrambler model supplies the keystream.
`timescale 1ns/1ps
module tb_usb3_descramble;

  localparam logic [15:0] SEED = 16'hFFFF;

  logic        local_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] raw_data;
  logic [3:0]  raw_datak;
  logic        raw_active;
  logic [31:0] proc_data;
  logic [3:0]  proc_datak;
  logic        proc_valid;
  logic [15:0] skp_count;
  logic        err_overflow;

  int errors = 0;
  int checks = 0;
  logic [15:0] m_lfsr;

  always #5 local_clk = ~local_clk;

  usb3_descramble #(.LFSR_SEED(SEED)) dut (
    .local_clk    (local_clk),
    .reset        (reset),
    .enable       (enable),
    .raw_data     (raw_data),
    .raw_datak    (raw_datak),
    .raw_active   (raw_active),
    .proc_data    (proc_data),
    .proc_datak   (proc_datak),
    .proc_valid   (proc_valid),
    .skp_count    (skp_count),
    .err_overflow (err_overflow)
  );

  task automatic cycle();
    @(posedge local_clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic [3:0] k);
    raw_data   = d;
    raw_datak  = k;
    raw_active = 1'b1;
  endtask

  task automatic idle();
    raw_data   = '0;
    raw_datak  = '0;
    raw_active = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    m_lfsr = SEED;
  endtask

  // Bit-serial reference: each data bit (LSB first) meets the current LFSR MSB.
  task automatic model_word(input logic [31:0] d, input logic [3:0] k, output logic [31:0] q);
    logic [7:0] b, key;
    q = '0;
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      if (k[i] && b == 8'hBC) begin
        m_lfsr = SEED;
        q[8*i +: 8] = b;
      end else if (k[i] && b == 8'h3C) begin
        q[8*i +: 8] = b;
      end else begin
        key = '0;
        for (int j = 0; j < 8; j++) begin
          key[j] = m_lfsr[15];
          m_lfsr = m_lfsr[15] ? ((m_lfsr << 1) ^ 16'h0039) : (m_lfsr << 1);
        end
        q[8*i +: 8] = (k[i] || !enable) ? b : (b ^ key);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    enable = 1'b1;
    reset  = 1'b1;
    cycle();
    checks++; if (proc_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want %h", proc_data, 32'h0); end
    checks++; if (proc_datak !== 4'h0) begin errors++; $display("FAIL rst_datak: got %h want %h", proc_datak, 4'h0); end
    checks++; if (proc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", proc_valid); end
    checks++; if (skp_count !== 16'h0) begin errors++; $display("FAIL rst_skp: got %h want 0", skp_count); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_overflow); end
    reset = 1'b0;
    cycle();
    m_lfsr = SEED;
  endtask

  task automatic test_com_reseed();
    logic [31:0] q0, q1;
    apply_reset();
    enable = 1'b1;
    put(32'h000000BC, 4'b0001); model_word(32'h000000BC, 4'b0001, q0);
    cycle();
    checks++; if (proc_valid !== 1'b0) begin errors++; $display("FAIL com_early: got %b want 0", proc_valid); end
    put(32'h00000000, 4'b0000); model_word(32'h00000000, 4'b0000, q1);
    cycle();
    checks++; if (proc_valid !== 1'b1) begin errors++; $display("FAIL com_valid: got %b want 1", proc_valid); end
    checks++; if (proc_data !== 32'hC017FFBC) begin errors++; $display("FAIL com_data0: got %h want %h", proc_data, 32'hC017FFBC); end
    checks++; if (proc_datak !== 4'b0001) begin errors++; $display("FAIL com_datak0: got %b want 0001", proc_datak); end
    idle();
    cycle();
    checks++; if (proc_data !== q1) begin errors++; $display("FAIL com_data1: got %h want %h", proc_data, q1); end
    checks++; if (proc_datak !== 4'b0000) begin errors++; $display("FAIL com_datak1: got %b want 0000", proc_datak); end
    cycle();
    checks++; if (proc_valid !== 1'b0) begin errors++; $display("FAIL com_strobe: got %b want 0", proc_valid); end
  endtask

  task automatic test_bypass();
    logic [31:0] q;
    apply_reset();
    enable = 1'b0;
    put(32'hDEADBEEF, 4'b0000); model_word(32'hDEADBEEF, 4'b0000, q);
    cycle();
    put(32'h01234567, 4'b0000); model_word(32'h01234567, 4'b0000, q);
    cycle();
    checks++; if (proc_data !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_data0: got %h want %h", proc_data, 32'hDEADBEEF); end
    idle();
    cycle();
    checks++; if (proc_data !== 32'h01234567) begin errors++; $display("FAIL byp_data1: got %h want %h", proc_data, 32'h01234567); end
  endtask

  // Follows bypass without reset: the keystream must have kept running while disabled.
  task automatic test_back_to_back();
    logic [31:0] q0, q1, q2;
    enable = 1'b1;
    put(32'hA5A5A5A5, 4'b0000); model_word(32'hA5A5A5A5, 4'b0000, q0);
    cycle();
    put(32'h5AF75A5A, 4'b0100); model_word(32'h5AF75A5A, 4'b0100, q1);
    cycle();
    checks++; if (proc_data !== q0) begin errors++; $display("FAIL b2b_data0: got %h want %h", proc_data, q0); end
    put(32'h00FF00FF, 4'b0000); model_word(32'h00FF00FF, 4'b0000, q2);
    cycle();
    checks++; if (proc_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", proc_valid); end
    checks++; if (proc_data !== q1) begin errors++; $display("FAIL b2b_data1: got %h want %h", proc_data, q1); end
    checks++; if (proc_datak !== 4'b0100) begin errors++; $display("FAIL b2b_datak1: got %b want 0100", proc_datak); end
    idle();
    cycle();
    checks++; if (proc_data !== q2) begin errors++; $display("FAIL b2b_data2: got %h want %h", proc_data, q2); end
    cycle();
    checks++; if (proc_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", proc_valid); end
  endtask

`ifdef USB3_DESCRAMBLE_SKP_STRIP_EN
  task automatic test_skp_mid();
    logic [31:0] qa, qb, qc, exp;
    apply_reset();
    enable = 1'b1;
    put(32'h333C3C11, 4'b0110); model_word(32'h333C3C11, 4'b0110, qa);
    cycle();
    put(32'h77665544, 4'b0000); model_word(32'h77665544, 4'b0000, qb);
    cycle();
    checks++; if (proc_valid !== 1'b0) begin errors++; $display("FAIL skp_nohit: got %b want 0", proc_valid); end
    checks++; if (skp_count !== 16'd2) begin errors++; $display("FAIL skp_count: got %0d want 2", skp_count); end
    idle();
    cycle();
    exp = {qb[15:8], qb[7:0], qa[31:24], qa[7:0]};
    checks++; if (proc_valid !== 1'b1) begin errors++; $display("FAIL skp_valid: got %b want 1", proc_valid); end
    checks++; if (proc_data !== exp) begin errors++; $display("FAIL skp_pack0: got %h want %h", proc_data, exp); end
    checks++; if (proc_datak !== 4'b0000) begin errors++; $display("FAIL skp_datak: got %b want 0000", proc_datak); end
    put(32'h00000000, 4'b0000); model_word(32'h00000000, 4'b0000, qc);
    cycle();
    idle();
    cycle();
    exp = {qc[15:8], qc[7:0], qb[31:24], qb[23:16]};
    checks++; if (proc_data !== exp) begin errors++; $display("FAIL skp_pack1: got %h want %h", proc_data, exp); end
    checks++; if (skp_count !== 16'd2) begin errors++; $display("FAIL skp_hold: got %0d want 2", skp_count); end
  endtask

  task automatic test_all_skp();
    logic [31:0] q1, qs, q2;
    apply_reset();
    enable = 1'b1;
    put(32'h04030201, 4'b0000); model_word(32'h04030201, 4'b0000, q1);
    cycle();
    put(32'h3C3C3C3C, 4'b1111); model_word(32'h3C3C3C3C, 4'b1111, qs);
    cycle();
    checks++; if (proc_data !== q1) begin errors++; $display("FAIL allskp_d1: got %h want %h", proc_data, q1); end
    put(32'h08070605, 4'b0000); model_word(32'h08070605, 4'b0000, q2);
    cycle();
    checks++; if (proc_valid !== 1'b0) begin errors++; $display("FAIL allskp_noemit: got %b want 0", proc_valid); end
    checks++; if (skp_count !== 16'd4) begin errors++; $display("FAIL allskp_count: got %0d want 4", skp_count); end
    idle();
    cycle();
    checks++; if (proc_valid !== 1'b1) begin errors++; $display("FAIL allskp_valid: got %b want 1", proc_valid); end
    checks++; if (proc_data !== q2) begin errors++; $display("FAIL allskp_d2: got %h want %h", proc_data, q2); end
  endtask
`else
  task automatic test_skp_passthru();
    logic [31:0] qa, qb;
    apply_reset();
    enable = 1'b1;
    put(32'h333C3C11, 4'b0110); model_word(32'h333C3C11, 4'b0110, qa);
    cycle();
    put(32'h00000000, 4'b0000); model_word(32'h00000000, 4'b0000, qb);
    cycle();
    checks++; if (proc_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b want 1", proc_valid); end
    checks++; if (proc_data !== qa) begin errors++; $display("FAIL pass_data0: got %h want %h", proc_data, qa); end
    checks++; if (proc_datak !== 4'b0110) begin errors++; $display("FAIL pass_datak: got %b want 0110", proc_datak); end
    idle();
    cycle();
    checks++; if (proc_data !== qb) begin errors++; $display("FAIL pass_data1: got %h want %h", proc_data, qb); end
    checks++; if (skp_count !== 16'd0) begin errors++; $display("FAIL pass_skp: got %0d want 0", skp_count); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] q;
    apply_reset();
    enable = 1'b1;
    put(32'h3C112233, 4'b1000); model_word(32'h3C112233, 4'b1000, q);
    cycle();
    idle();
    cycle();
`ifdef USB3_DESCRAMBLE_SKP_STRIP_EN
    checks++; if (skp_count !== 16'd1) begin errors++; $display("FAIL rmid_pre_skp: got %0d want 1", skp_count); end
`else
    checks++; if (proc_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", proc_valid); end
`endif
    reset = 1'b1;
    #1;
    checks++; if (proc_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h want 0", proc_data); end
    checks++; if (proc_datak !== 4'h0) begin errors++; $display("FAIL rmid_datak: got %h want 0", proc_datak); end
    checks++; if (proc_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", proc_valid); end
    checks++; if (skp_count !== 16'h0) begin errors++; $display("FAIL rmid_skp: got %h want 0", skp_count); end
    #1;
    reset  = 1'b0;
    m_lfsr = SEED;
    put(32'h00000000, 4'b0000); model_word(32'h00000000, 4'b0000, q);
    cycle();
    idle();
    cycle();
    checks++; if (proc_valid !== 1'b1) begin errors++; $display("FAIL rmid_post_valid: got %b want 1", proc_valid); end
    checks++; if (proc_data !== q) begin errors++; $display("FAIL rmid_post_data: got %h want %h", proc_data, q); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle();
    enable = 1'b1;
    reset  = 1'b0;
    #2;
    test_reset();
    test_com_reseed();
    test_bypass();
    test_back_to_back();
`ifdef USB3_DESCRAMBLE_SKP_STRIP_EN
    test_skp_mid();
    test_all_skp();
`else
    test_skp_passthru();
`endif
    test_reset_mid();
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL final_err: got %b want 0", err_overflow); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
